// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the reaction-timer scoring path.
//   result_t        : one measured reaction time in microsecond ticks
//   disp_sel_e      : which statistic the BCD/layout stage is showing
//   RESULT_TIMEOUT  : value the measurement counter parks at when nobody reacts
// -----------------------------------------------------------------------------
package score_pkg;

    typedef logic [19:0] result_t;

    typedef enum logic [1:0] {
        DISP_LAST = 2'd0,
        DISP_BEST = 2'd1,
        DISP_AVG  = 2'd2
    } disp_sel_e;

    localparam result_t RESULT_TIMEOUT = '1;

endpackage

// File: rtl/score_avg.sv
// -----------------------------------------------------------------------------
// score_avg
// Rolling mean of the last DEPTH accepted reaction times.
// Keeps a ring buffer of DEPTH entries, a running sum and a fill count.  On each
// accepted sample the oldest entry is subtracted and the new one added, so the
// sum always equals the sum of the buffer.  The mean is registered one cycle
// later (two cycles after the input strobe at the top level).
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_clear      synchronous wipe of buffer, sum, fill and mean
//   i_accept     one-cycle strobe: i_result is an accepted sample
//   i_result     sample value (W bits)
//   o_avg        registered mean of the window
//   o_avg_valid  window has been completely filled since reset/clear
// -----------------------------------------------------------------------------
module score_avg
    import score_pkg::*;
#(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_accept,
    input  logic [W-1:0] i_result,
    output logic [W-1:0] o_avg,
    output logic         o_avg_valid
);

    localparam int unsigned SHIFT = $clog2(DEPTH);
    localparam int unsigned SW    = W + SHIFT;
    localparam int unsigned FW    = SHIFT + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

    logic [W-1:0]     ring_view [DEPTH];
    logic [SHIFT-1:0] wp_reg;
    logic [FW-1:0]    fill_reg;
    logic [SW-1:0]    sum_reg;
    logic [SW-1:0]    sum_next;
    logic [W-1:0]     oldest;
    logic [W-1:0]     avg_reg;
    logic             avg_valid_reg;

    // Entries start at zero, so subtracting the slot being overwritten is exact
    // even while the window is still filling.
    assign oldest   = ring_view[wp_reg];
    assign sum_next = sum_reg - SW'(oldest) + SW'(i_result);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ring
            logic [W-1:0] entry_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    entry_reg <= '0;
                end else if (i_clear) begin
                    entry_reg <= '0;
                end else if (i_accept && (wp_reg == SHIFT'(gi))) begin
                    entry_reg <= i_result;
                end
            end

            assign ring_view[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wp_reg        <= '0;
            fill_reg      <= '0;
            sum_reg       <= '0;
            avg_reg       <= '0;
            avg_valid_reg <= 1'b0;
        end else if (i_clear) begin
            wp_reg        <= '0;
            fill_reg      <= '0;
            sum_reg       <= '0;
            avg_reg       <= '0;
            avg_valid_reg <= 1'b0;
        end else begin
            if (i_accept) begin
                sum_reg <= sum_next;
                // DEPTH is a power of two, so the pointer wraps on overflow.
                wp_reg  <= wp_reg + 1'b1;
                if (fill_reg != FILL_FULL) begin
                    fill_reg <= fill_reg + 1'b1;
                end
            end
            // Mean and its valid flag follow the sum one cycle later, so they
            // change together on the same edge.
            avg_reg       <= W'(sum_reg >> SHIFT);
            avg_valid_reg <= (fill_reg == FILL_FULL);
        end
    end

    assign o_avg       = avg_reg;
    assign o_avg_valid = avg_valid_reg;

endmodule

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Consumes finished reaction-time measurements, rejects implausible ones and
// keeps last / best / rolling-average statistics plus attempt counters.  Also
// paces a display selector that rotates through the statistics every
// FRAME_DIV video frames.
//
// Build option: define SCORE_AVG_EN to include the rolling average (score_avg)
// and the DISP_AVG display slot.  Without it o_avg and o_avg_valid are tied to
// zero and the display alternates LAST <-> BEST only.
//
// Ports
//   i_clk         system clock (pixel clock)
//   i_rst         asynchronous active-high reset
//   i_valid       one-cycle strobe: new measurement on i_result
//   i_result      measured reaction time in microseconds
//   i_clear       one-cycle strobe: wipe statistics (o_last is kept)
//   i_of          end-of-frame strobe from the video timing generator
//   o_last        last accepted result
//   o_best        minimum accepted result
//   o_best_valid  o_best holds a real value
//   o_avg         mean of the last DEPTH accepted results
//   o_avg_valid   DEPTH results accumulated since reset/clear
//   o_count       accepted attempts, saturating at 255
//   o_rejects     rejected attempts, saturating at 255
//   o_new_best    one-cycle pulse when o_best improves
//   o_reject      one-cycle pulse when a result is rejected
//   o_sel         display select (disp_sel_e encoding)
// -----------------------------------------------------------------------------
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned W          = 20,
    parameter int unsigned MIN_RESULT = 80000,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FRAME_DIV  = 120
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_result,
    input  logic         i_clear,
    input  logic         i_of,
    output logic [W-1:0] o_last,
    output logic [W-1:0] o_best,
    output logic         o_best_valid,
    output logic [W-1:0] o_avg,
    output logic         o_avg_valid,
    output logic [7:0]   o_count,
    output logic [7:0]   o_rejects,
    output logic         o_new_best,
    output logic         o_reject,
    output logic [1:0]   o_sel
);

    localparam logic [W-1:0] MIN_R   = W'(MIN_RESULT);
    localparam logic [W-1:0] TIMEOUT = {W{1'b1}};
    localparam int unsigned  FRW     = $clog2(FRAME_DIV);
    localparam logic [FRW-1:0] FRAME_LAST = FRW'(FRAME_DIV - 1);

    // Elaboration-time guard on the window size (power of two, 2..16).
    generate
        if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("score_keeper: DEPTH must be a power of two in 2..16");
        end
        if (FRAME_DIV < 2) begin : g_bad_frame_div
            $error("score_keeper: FRAME_DIV must be at least 2");
        end
    endgenerate

    logic [W-1:0] last_reg;
    logic [W-1:0] best_reg;
    logic         best_valid_reg;
    logic [7:0]   count_reg;
    logic [7:0]   rejects_reg;
    logic         new_best_reg;
    logic         reject_reg;
    disp_sel_e    sel_reg;
    disp_sel_e    sel_next;
    logic [FRW-1:0] frame_reg;
    logic [FRW-1:0] frame_next;

    logic         sample_ok;
    logic         take;
    logic         accept;
    logic         reject;
    logic         improves;
    logic [W-1:0] avg;
    logic         avg_valid;

    // ------------------------------------------------------------------
    // Sample classification.  Clear wins over a coincident strobe, so the
    // sample is simply not taken in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        sample_ok = (i_result >= MIN_R) && (i_result != TIMEOUT);
        take      = i_valid && !i_clear;
        accept    = take && sample_ok;
        reject    = take && !sample_ok;
        // A tie with the current best is not an improvement.
        improves  = !best_valid_reg || (i_result < best_reg);
    end

    // ------------------------------------------------------------------
    // Statistics registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_reg       <= '0;
            best_reg       <= '0;
            best_valid_reg <= 1'b0;
            count_reg      <= '0;
            rejects_reg    <= '0;
            new_best_reg   <= 1'b0;
            reject_reg     <= 1'b0;
        end else begin
            new_best_reg <= 1'b0;
            reject_reg   <= 1'b0;
            if (i_clear) begin
                // o_last deliberately survives a clear.
                best_reg       <= '0;
                best_valid_reg <= 1'b0;
                count_reg      <= '0;
                rejects_reg    <= '0;
            end else if (accept) begin
                last_reg <= i_result;
                if (count_reg != 8'hFF) begin
                    count_reg <= count_reg + 8'd1;
                end
                if (improves) begin
                    best_reg       <= i_result;
                    best_valid_reg <= 1'b1;
                    new_best_reg   <= 1'b1;
                end
            end else if (reject) begin
                reject_reg <= 1'b1;
                if (rejects_reg != 8'hFF) begin
                    rejects_reg <= rejects_reg + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Rolling average (optional)
    // ------------------------------------------------------------------
`ifdef SCORE_AVG_EN
    score_avg #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_avg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_clear),
        .i_accept    (accept),
        .i_result    (i_result),
        .o_avg       (avg),
        .o_avg_valid (avg_valid)
    );
`else
    assign avg       = '0;
    assign avg_valid = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Display selector FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_reg   <= DISP_LAST;
            frame_reg <= '0;
        end else begin
            sel_reg   <= sel_next;
            frame_reg <= frame_next;
        end
    end

    // ------------------------------------------------------------------
    // Display selector FSM: next state
    // A fresh result always goes to the screen immediately and restarts the
    // slot timer; otherwise the slot advances after FRAME_DIV frames, skipping
    // statistics that do not hold a value yet.
    // ------------------------------------------------------------------
    always_comb begin
        sel_next   = sel_reg;
        frame_next = frame_reg;
        if (i_clear || accept) begin
            sel_next   = DISP_LAST;
            frame_next = '0;
        end else if (i_of) begin
            if (frame_reg == FRAME_LAST) begin
                frame_next = '0;
                case (sel_reg)
                    DISP_LAST: begin
                        if (best_valid_reg) begin
                            sel_next = DISP_BEST;
                        end else if (avg_valid) begin
                            sel_next = DISP_AVG;
                        end else begin
                            sel_next = DISP_LAST;
                        end
                    end
                    DISP_BEST: begin
                        sel_next = avg_valid ? DISP_AVG : DISP_LAST;
                    end
                    default: begin
                        sel_next = DISP_LAST;
                    end
                endcase
            end else begin
                frame_next = frame_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_last       = last_reg;
    assign o_best       = best_reg;
    assign o_best_valid = best_valid_reg;
    assign o_avg        = avg;
    assign o_avg_valid  = avg_valid;
    assign o_count      = count_reg;
    assign o_rejects    = rejects_reg;
    assign o_new_best   = new_best_reg;
    assign o_reject     = reject_reg;
    assign o_sel        = sel_reg;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
// Self-checking bench for score_keeper.  Inputs are driven on the falling
// edge; every falling edge all outputs are compared with a behavioural model
// that keeps the statistics as plain numbers and a queue of recent samples.
// Directed sequences come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_score_keeper;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MIN_RES   = 80000;
    localparam int unsigned FRAME_DIV = 120;
`ifdef SCORE_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [19:0] i_result;
    logic        i_clear;
    logic        i_of;
    logic [19:0] o_last;
    logic [19:0] o_best;
    logic        o_best_valid;
    logic [19:0] o_avg;
    logic        o_avg_valid;
    logic [7:0]  o_count;
    logic [7:0]  o_rejects;
    logic        o_new_best;
    logic        o_reject;
    logic [1:0]  o_sel;

    always #5 clk = ~clk;

    score_keeper #(
        .W          (20),
        .MIN_RESULT (MIN_RES),
        .DEPTH      (DEPTH),
        .FRAME_DIV  (FRAME_DIV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_result     (i_result),
        .i_clear      (i_clear),
        .i_of         (i_of),
        .o_last       (o_last),
        .o_best       (o_best),
        .o_best_valid (o_best_valid),
        .o_avg        (o_avg),
        .o_avg_valid  (o_avg_valid),
        .o_count      (o_count),
        .o_rejects    (o_rejects),
        .o_new_best   (o_new_best),
        .o_reject     (o_reject),
        .o_sel        (o_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (expected outputs after the most recent edge)
    int unsigned m_last, m_best, m_avg;
    bit          m_bv, m_av, m_nb, m_rj;
    int          m_count, m_rejects, m_sel, m_frame;
    int unsigned m_win[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_last"},       32'(o_last),       m_last);
        check({pfx, "_best"},       32'(o_best),       m_best);
        check({pfx, "_best_valid"}, 32'(o_best_valid), 32'(m_bv));
        check({pfx, "_avg"},        32'(o_avg),        m_avg);
        check({pfx, "_avg_valid"},  32'(o_avg_valid),  32'(m_av));
        check({pfx, "_count"},      32'(o_count),      32'(m_count));
        check({pfx, "_rejects"},    32'(o_rejects),    32'(m_rejects));
        check({pfx, "_new_best"},   32'(o_new_best),   32'(m_nb));
        check({pfx, "_reject"},     32'(o_reject),     32'(m_rj));
        check({pfx, "_sel"},        32'(o_sel),        32'(m_sel));
    endtask

    task automatic model_reset();
        m_last = 0; m_best = 0; m_avg = 0;
        m_bv = 0; m_av = 0; m_nb = 0; m_rj = 0;
        m_count = 0; m_rejects = 0; m_sel = 0; m_frame = 0;
        m_win.delete();
    endtask

    // Rotation order LAST(0) -> BEST(1) -> AVG(2); pick the first slot after
    // the current one that has something to show.
    function automatic int next_slot(int cur, bit bv, bit av);
        for (int k = 1; k <= 3; k++) begin
            int cand;
            cand = (cur + k) % 3;
            if (cand == 0 || (cand == 1 && bv) || (cand == 2 && av && AVG_EN)) return cand;
        end
        return 0;
    endfunction

    task automatic model_step(input bit v, input int unsigned r, input bit c, input bit f);
        bit     pre_bv, pre_av, bad;
        longint s;
        pre_bv = m_bv;
        pre_av = m_av;
        m_nb = 0;
        m_rj = 0;
        if (c) begin
            m_best = 0; m_bv = 0; m_count = 0; m_rejects = 0;
            m_avg = 0; m_av = 0; m_sel = 0; m_frame = 0;
            m_win.delete();
        end else begin
            if (AVG_EN) begin
                // Mean of the window as it stood before this edge; missing
                // entries count as zero.
                s = 0;
                foreach (m_win[k]) s += m_win[k];
                m_avg = int'(s / DEPTH);
                m_av  = (m_win.size() == DEPTH);
            end
            bad = (r < MIN_RES) || (r == 20'hFFFFF);
            if (v && bad) begin
                m_rj = 1;
                if (m_rejects < 255) m_rejects++;
            end
            if (v && !bad) begin
                m_last = r;
                if (m_count < 255) m_count++;
                if (!m_bv || r < m_best) begin
                    m_best = r; m_bv = 1; m_nb = 1;
                end
                m_win.push_back(r);
                if (m_win.size() > DEPTH) void'(m_win.pop_front());
                m_sel = 0;
                m_frame = 0;
            end else if (f) begin
                if (m_frame == FRAME_DIV - 1) begin
                    m_frame = 0;
                    m_sel = next_slot(m_sel, pre_bv, pre_av);
                end else begin
                    m_frame++;
                end
            end
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model,
    // then compare everything at the next falling edge.
    task automatic cyc(input bit v, input int unsigned r, input bit c, input bit f, input string tag);
        i_valid  = v;
        i_result = r[19:0];
        i_clear  = c;
        i_of     = f;
        model_step(v, r, c, f);
        if (v || c)
            $display("txn %s t=%0t valid=%0b result=%0d clear=%0b", tag, $time, v, r, c);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, tag);
    endtask

    function automatic int unsigned pick_result();
        int unsigned kind;
        kind = $urandom_range(0, 9);
        case (kind)
            0: return $urandom_range(0, MIN_RES - 1);
            1: return 20'hFFFFF;
            2: return MIN_RES;
            3: return MIN_RES - 1;
            4: return m_bv ? m_best : MIN_RES + 1;
            5: return 20'hFFFFE;
            default: return $urandom_range(MIN_RES, 400000);
        endcase
    endfunction

    int unsigned saved_last;

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_result = '0; i_clear = 1'b0; i_of = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check_all("reset");

        // First accept
        cyc(1, 250000, 0, 0, "acc1");
        check("acc1_last_const", 32'(o_last), 250000);
        check("acc1_newbest_const", 32'(o_new_best), 1);
        idle(1, "acc1_idle");

        // Worse, better, equal
        cyc(1, 300000, 0, 0, "worse");
        cyc(1, 200000, 0, 0, "better");
        check("better_best_const", 32'(o_best), 200000);
        cyc(1, 200000, 0, 0, "equal");
        check("equal_nopulse_const", 32'(o_new_best), 0);

        // Rejections: anticipation and timeout
        cyc(1, 50000, 0, 0, "rej_low");
        cyc(1, 20'hFFFFF, 0, 0, "rej_to");
        check("rej_rejects_const", 32'(o_rejects), 2);
        cyc(1, MIN_RES - 1, 0, 0, "rej_edge");
        cyc(1, MIN_RES, 0, 0, "acc_edge");
        idle(2, "idle");

        // Clear, then fill the averaging window from empty
        cyc(0, 0, 1, 0, "clear");
        cyc(1, 100000, 0, 0, "avg1");
        cyc(1, 200000, 0, 0, "avg2");
        cyc(1, 300000, 0, 0, "avg3");
        cyc(1, 400000, 0, 0, "avg4");
        idle(1, "avg_wait");
        if (AVG_EN) check("avg4_const", 32'(o_avg), 250000);
        cyc(1, 500000, 0, 0, "avg5");
        idle(1, "avg_wait");
        if (AVG_EN) check("avg5_const", 32'(o_avg), 350000);

        // Display rotation
        for (int k = 0; k < FRAME_DIV; k++) cyc(0, 0, 0, 1, "rot1");
        check("rot1_sel_const", 32'(o_sel), 1);
        for (int k = 0; k < FRAME_DIV; k++) cyc(0, 0, 0, 1, "rot2");
        check("rot2_sel_const", 32'(o_sel), AVG_EN ? 2 : 0);
        for (int k = 0; k < 60; k++) cyc(0, 0, 0, 1, "rot3");
        cyc(1, 450000, 0, 1, "rot_acc");
        check("rot_acc_sel_const", 32'(o_sel), 0);
        for (int k = 0; k < FRAME_DIV; k++) cyc(0, 0, 0, 1, "rot4");

        // Clear coincident with a valid sample
        saved_last = 32'(o_last);
        cyc(1, 150000, 1, 0, "clr_valid");
        check("clr_last_kept", 32'(o_last), saved_last);
        check("clr_count_const", 32'(o_count), 0);
        check("clr_bv_const", 32'(o_best_valid), 0);
        idle(2, "clr_idle");

        // Randomized traffic: dense samples, then sparse samples with frequent frames
        for (int k = 0; k < 1000; k++) begin
            bit v, c, f;
            v = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 3) == 0);
            cyc(v, v ? pick_result() : 0, c, f, "rnd_a");
        end
        for (int k = 0; k < 2500; k++) begin
            bit v, c, f;
            v = ($urandom_range(0, 149) == 0);
            c = ($urandom_range(0, 999) == 0);
            f = ($urandom_range(0, 3) != 0);
            cyc(v, v ? pick_result() : 0, c, f, "rnd_b");
        end

        // Asynchronous reset in the middle of a frame slot
        cyc(1, 120000, 0, 0, "pre_rst");
        for (int k = 0; k < 30; k++) cyc(0, 0, 0, 1, "pre_rst_of");
        i_valid = 1'b1; i_result = 20'd130000; i_of = 1'b1;
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        i_rst = 1'b0; i_valid = 1'b0; i_of = 1'b0;
        check_all("after_rst");
        cyc(1, 260000, 0, 0, "post_rst");
        idle(2, "post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits between the reaction-timer FSM and the BCD/layout stage. Consumes each finished measurement and keeps the last, best (minimum) and rolling-average reaction times.
- Rejects implausible results and counts attempts.
- Generates the frame-paced display selector that picks which value the BCD converter shows.
- Replaces the constant best_result / bcd_mux path at top level.

Parameters:
- W, 20, result width in µs ticks (matches the measured counter).
- MIN_RESULT, 20'd80000, results below this (under 80 ms) are anticipations and are rejected.
- DEPTH, 4, rolling-average window; power of two, 2..16.
- FRAME_DIV, 120, VGA frames per display slot (about 2 s at 60 Hz).

Ports:
- i_clk  in  1  system clock (25.175 MHz pixel clock)
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  single-cycle strobe: new result on i_result
- i_result  in  W  measured reaction time, µs
- i_clear  in  1  single-cycle strobe: wipe statistics
- i_of  in  1  end-of-frame strobe from vga_timings
- o_last  out  W  last accepted result
- o_best  out  W  minimum accepted result
- o_best_valid  out  1  o_best holds a real value
- o_avg  out  W  mean of last DEPTH accepted results
- o_avg_valid  out  1  DEPTH results accumulated since reset/clear
- o_count  out  8  accepted attempts, saturating at 255
- o_rejects  out  8  rejected attempts, saturating at 255
- o_new_best  out  1  one-cycle pulse when o_best improves
- o_reject  out  1  one-cycle pulse when a result is rejected
- o_sel  out  2  display select, score_pkg::disp_sel_e

Behaviour:
- Reset (async, i_rst=1): every output and internal register goes to 0. This covers o_sel=DISP_LAST, the buffer contents, the write pointer, the fill count and the frame counter. Reset asserted mid-update discards that update.
- Rejection:
  - On i_valid, the sample is rejected if i_result < MIN_RESULT or i_result == all-ones (timeout).
  - Rejected: o_reject=1 on the next cycle; o_rejects increments, saturating. Nothing else changes.
- Acceptance:
  - Otherwise the sample is accepted, with all of the following visible the cycle after i_valid (latency 1):
    - o_last <= i_result.
    - o_count increments, saturating at 255.
    - If !o_best_valid or i_result < o_best: o_best <= i_result, o_best_valid <= 1, o_new_best pulses.
  - A sample equal to o_best is not a new best.
- Average:
  - Ring buffer of DEPTH entries, write pointer wp and fill count.
  - Running sum is W+log2(DEPTH) bits wide. On accept: sum <= sum - buf[wp] + i_result; buf[wp] <= i_result; wp wraps DEPTH-1 -> 0; fill saturates at DEPTH.
  - o_avg <= sum >> log2(DEPTH), registered; latency 2 cycles from i_valid.
  - o_avg_valid is asserted once fill == DEPTH, in the same cycle o_avg first reflects the full window.
  - Buffer entries are 0 after reset/clear, so subtract-oldest is exact during fill.
- Clear: i_clear resets o_best, o_best_valid, the average state, o_count and o_rejects. o_last is kept. If i_clear and i_valid coincide, clear wins and the sample is dropped with no pulses.
- Display FSM (states DISP_LAST, DISP_BEST, DISP_AVG):
  - The frame counter increments on i_of. At FRAME_DIV-1 it wraps to 0 and the state advances LAST -> BEST -> AVG -> LAST.
  - BEST is skipped when !o_best_valid; AVG is skipped when !o_avg_valid or the feature is disabled.
  - An accepted sample forces DISP_LAST and frame counter 0 on the same edge as the o_last update.
  - Accept takes priority over a simultaneous i_of advance.
  - Clear forces DISP_LAST.

Optional Feature:
- Macro SCORE_AVG_EN.
- Defined: the ring buffer, running sum and DISP_AVG slot exist as described.
- Undefined: no buffer or sum logic is synthesized; o_avg=0 and o_avg_valid=0 permanently; the display rotates LAST <-> BEST only. All other timing is unchanged.

Decomposition:
- score_pkg holds:
  - typedef result_t (logic [19:0]);
  - enum disp_sel_e (logic [1:0]: DISP_LAST=0, DISP_BEST=1, DISP_AVG=2);
  - localparam RESULT_TIMEOUT (all-ones).
- One sub-module, score_avg: ring buffer, running sum, fill/valid and registered mean. It is instantiated only under SCORE_AVG_EN.

Test Plan:
- Reset, then accept 250000 -> after 1 cycle: o_last=250000, o_best=250000, o_best_valid=1, o_new_best pulse, o_count=1, o_sel=DISP_LAST.
- Accept 300000 then 200000 -> o_best stays 250000 with no pulse, then becomes 200000 with a pulse. A later 200000 gives no pulse.
- Send 50000 and then 20'hFFFFF -> two o_reject pulses, o_rejects=2, o_last/o_best/o_count unchanged.
- (SCORE_AVG_EN) Accept 100000, 200000, 300000, 400000:
  - o_avg_valid rises 2 cycles after the 4th strobe, with o_avg=250000.
  - A 5th sample 500000 gives o_avg=350000.
- Pulse i_of 120 times with best valid and avg valid: o_sel steps LAST -> BEST. Another 120 steps to AVG (or LAST without the macro). An accept mid-count forces LAST.
- i_clear coincident with i_valid(150000) -> no pulses, o_best_valid=0, o_count=0, o_last unchanged. Asserting i_rst asynchronously mid-frame immediately zeroes all outputs.
